// File: rtl/gan_param_loader.sv
// gan_param_loader
// Byte-stream front end for the combinational gan datapath.
// Receives the 77 gan operands as signed bytes over a valid/ready stream.
// Each byte is sign-extended into a parameter register bank that drives
// gan's operand ports. Once a frame is complete, the loader waits SETTLE
// cycles and captures gan's four outputs. It then offers them on a
// result valid/ready handshake.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   s_valid    stream byte valid
//   s_data     signed operand byte
//   s_last     final byte of frame
//   s_ready    loader accepts a byte this cycle (registered)
//   params     operand bank, entry k at [k*WIDTH +: WIDTH]
//   out1..out4 gan outputs
//   res_valid  captured result held (registered)
//   res_ready  consumer accepts result
//   res1..res4 captured out1..out4
//   err        one-cycle framing-error pulse (registered)
module gan_param_loader #(
  parameter int WIDTH    = 32,
  parameter int IN_WIDTH = 8,
  parameter int SETTLE   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [IN_WIDTH-1:0]   s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [77*WIDTH-1:0]   params,
  input  logic [WIDTH-1:0]      out1,
  input  logic [WIDTH-1:0]      out2,
  input  logic [WIDTH-1:0]      out3,
  input  logic [WIDTH-1:0]      out4,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res1,
  output logic [WIDTH-1:0]      res2,
  output logic [WIDTH-1:0]      res3,
  output logic [WIDTH-1:0]      res4,
  output logic                  err
);

  localparam int         NPARAM   = 77;
  localparam logic [6:0] LAST_IDX = 7'd76;
  // A SETTLE of 1 still needs a 1-bit counter that holds zero.
  localparam int         CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_DRAIN,
    ST_SETTLE,
    ST_RESULT
  } state_t;

  state_t                r_state;
  logic [6:0]            r_idx;
  logic [CW-1:0]         r_cnt;
  logic                  r_s_ready;
  logic                  r_res_valid;
  logic                  r_err;
  logic [WIDTH-1:0]      r_res1;
  logic [WIDTH-1:0]      r_res2;
  logic [WIDTH-1:0]      r_res3;
  logic [WIDTH-1:0]      r_res4;

  logic                  w_xfer;
  logic                  w_bank_we;
  logic [WIDTH-1:0]      w_ext;

  assign w_xfer    = s_valid & r_s_ready;
  // Only LOAD writes the bank; DRAIN swallows bytes without touching it.
  assign w_bank_we = w_xfer && (r_state == ST_LOAD);

  // Sign extension: fill with the sign bit, then overlay the byte.
  always_comb begin
    w_ext                 = {WIDTH{s_data[IN_WIDTH-1]}};
    w_ext[IN_WIDTH-1:0]   = s_data;
  end

  // Control FSM. s_ready/res_valid are assigned alongside the state
  // transition, so they always reflect the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_s_ready   <= 1'b0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
      r_res1      <= '0;
      r_res2      <= '0;
      r_res3      <= '0;
      r_res4      <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          r_s_ready <= 1'b1;
          if (w_xfer) begin
            if (r_idx == LAST_IDX) begin
              r_idx <= '0;
              if (s_last) begin
                r_state   <= ST_SETTLE;
                r_cnt     <= CW'(SETTLE - 1);
                r_s_ready <= 1'b0;
              end else begin
                // Frame overran: discard bytes until the sender's s_last.
                r_err   <= 1'b1;
                r_state <= ST_DRAIN;
              end
            end else if (s_last) begin
              // Short frame: restart at index 0 and keep loading.
              r_err <= 1'b1;
              r_idx <= '0;
            end else begin
              r_idx <= r_idx + 7'd1;
            end
          end
        end
        ST_DRAIN: begin
          r_s_ready <= 1'b1;
          if (w_xfer && s_last) begin
            r_state <= ST_LOAD;
          end
        end
        ST_SETTLE: begin
          r_s_ready <= 1'b0;
          if (r_cnt == '0) begin
            r_res1      <= out1;
            r_res2      <= out2;
            r_res3      <= out3;
            r_res4      <= out4;
            r_res_valid <= 1'b1;
            r_state     <= ST_RESULT;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_s_ready   <= 1'b1;
            r_state     <= ST_LOAD;
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  // Parameter bank: one register per operand, written in place with no
  // shadow copy. An aborted frame therefore leaves mixed old/new entries.
  genvar gi;
  generate
    for (gi = 0; gi < NPARAM; gi++) begin : g_bank
      logic [WIDTH-1:0] r_entry;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_entry <= '0;
        end else if (w_bank_we && (r_idx == 7'(gi))) begin
          r_entry <= w_ext;
        end
      end
      assign params[gi*WIDTH +: WIDTH] = r_entry;
    end
  endgenerate

  assign s_ready   = r_s_ready;
  assign res_valid = r_res_valid;
  assign err       = r_err;
  assign res1      = r_res1;
  assign res2      = r_res2;
  assign res3      = r_res3;
  assign res4      = r_res4;

endmodule

// File: tb/tb_gan_param_loader.sv
// Testbench for gan_param_loader.
// A table of whole-frame vectors is applied in a loop. Hand-written sequences
// follow for the backpressure, framing-error, drain and reset cases.
module tb_gan_param_loader;

  localparam int WIDTH    = 32;
  localparam int IN_WIDTH = 8;
  localparam int SETTLE   = 2;
  localparam int NP       = 77;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                s_valid = 1'b0;
  logic [IN_WIDTH-1:0] s_data = '0;
  logic                s_last = 1'b0;
  logic                s_ready;
  logic [NP*WIDTH-1:0] params;
  logic [WIDTH-1:0]    out1 = '0, out2 = '0, out3 = '0, out4 = '0;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic [WIDTH-1:0]    res1, res2, res3, res4;
  logic                err;

  gan_param_loader #(.WIDTH(WIDTH), .IN_WIDTH(IN_WIDTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .params(params),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .res_valid(res_valid), .res_ready(res_ready),
    .res1(res1), .res2(res2), .res3(res3), .res4(res4),
    .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int err_cnt = 0;
  always @(posedge clk) if (err === 1'b1) err_cnt <= err_cnt + 1;

  int nvec = 0;
  int nmis = 0;
  int last_acc = 0;

  logic [7:0]       std_bytes [NP];
  logic [WIDTH-1:0] exp_bank  [NP];

  typedef struct {
    logic [7:0]       b0;
    bit               gap;
    bit               early_rdy;
    logic [WIDTH-1:0] o1, o2, o3, o4;
    logic [WIDTH-1:0] e1, e2, e3, e4;
    logic [WIDTH-1:0] e_p0;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_bank(input string name);
    int bad;
    bad = -1;
    for (int k = 0; k < NP; k++)
      if (bad < 0 && params[k*WIDTH +: WIDTH] !== exp_bank[k]) bad = k;
    nvec++;
    if (bad >= 0) begin
      nmis++;
      $display("FAIL %s: bank[%0d] got %h, required %h", name, bad,
               params[bad*WIDTH +: WIDTH], exp_bank[bad]);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < NP; k++) exp_bank[k] = '0;
    check($sformatf("%s_s_ready", tag), 32'(s_ready), 32'd0);
    check($sformatf("%s_res_valid", tag), 32'(res_valid), 32'd0);
    check($sformatf("%s_err", tag), 32'(err), 32'd0);
    check($sformatf("%s_res1", tag), res1, 32'd0);
    check($sformatf("%s_res4", tag), res4, 32'd0);
    check_bank($sformatf("%s_bank", tag));
  endtask

  // Entered and left at a falling edge; the byte is accepted on the
  // rising edge in between, and last_acc records that edge.
  task automatic send_byte(input logic [7:0] d, input logic last, input bit gap);
    int n;
    if (gap) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      nvec++;
      nmis++;
      $display("FAIL accept_timeout: s_ready=%b, required 1", s_ready);
    end
    @(negedge clk);
    last_acc = cyc;
    s_valid  = 1'b0;
    s_last   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input bit gap);
    logic [7:0] d;
    for (int k = 0; k < NP; k++) begin
      d = (k == 0) ? b0 : std_bytes[k];
      send_byte(d, k == NP - 1, gap);
      exp_bank[k] = 32'($signed(d));
    end
  endtask

  task automatic wait_result(input string tag, input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2,
                             input logic [WIDTH-1:0] e3, input logic [WIDTH-1:0] e4);
    int n;
    bit sr_bad;
    n = 0;
    sr_bad = 0;
    while (res_valid !== 1'b1 && n < 50) begin
      if (s_ready !== 1'b0) sr_bad = 1;
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_res_timeout", tag), 32'(n < 50), 32'd1);
    check($sformatf("%s_latency", tag), 32'(cyc - last_acc), 32'(SETTLE));
    check($sformatf("%s_sready_low", tag), 32'(sr_bad), 32'd0);
    check($sformatf("%s_res1", tag), res1, e1);
    check($sformatf("%s_res2", tag), res2, e2);
    check($sformatf("%s_res3", tag), res3, e3);
    check($sformatf("%s_res4", tag), res4, e4);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b0, input bit gap, input bit early,
                          input int hold, input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2,
                          input logic [WIDTH-1:0] e3, input logic [WIDTH-1:0] e4);
    bit bad;
    res_ready = early;
    send_frame(b0, gap);
    wait_result(tag, e1, e2, e3, e4);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      if (i == 5) out1 = 32'd99;
      if (res_valid !== 1'b1 || res1 !== e1 || res2 !== e2 || s_ready !== 1'b0) bad = 1;
      @(negedge clk);
    end
    if (hold > 0) check($sformatf("%s_hold_stable", tag), 32'(bad), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check($sformatf("%s_hs_res_valid", tag), 32'(res_valid), 32'd0);
    check($sformatf("%s_hs_s_ready", tag), 32'(s_ready), 32'd1);
    check_bank($sformatf("%s_bank", tag));
    check($sformatf("%s_p5", tag), params[5*WIDTH +: WIDTH], 32'h0000_0001);
    check($sformatf("%s_p8", tag), params[8*WIDTH +: WIDTH], 32'hFFFF_FFFD);
    check($sformatf("%s_p76", tag), params[76*WIDTH +: WIDTH], 32'hFFFF_FFF6);
  endtask

  initial begin
    for (int k = 0; k < NP; k++) begin
      std_bytes[k] = 8'(((k * 7) % 23) - 11);
      exp_bank[k]  = '0;
    end
    std_bytes[0]  = 8'd0;
    std_bytes[1]  = 8'd1;
    std_bytes[2]  = 8'd1;
    std_bytes[3]  = 8'd0;
    std_bytes[4]  = 8'd6;
    std_bytes[5]  = 8'd1;
    std_bytes[8]  = 8'hFD;
    std_bytes[76] = 8'hF6;

    vecs[0] = '{b0: 8'h00, gap: 0, early_rdy: 0,
                o1: 32'd11, o2: -32'sd22, o3: 32'd33, o4: -32'sd44,
                e1: 32'h0000_000B, e2: 32'hFFFF_FFEA, e3: 32'h0000_0021, e4: 32'hFFFF_FFD4,
                e_p0: 32'h0000_0000};
    vecs[1] = '{b0: 8'h80, gap: 1, early_rdy: 0,
                o1: 32'd11, o2: -32'sd22, o3: 32'd33, o4: -32'sd44,
                e1: 32'h0000_000B, e2: 32'hFFFF_FFEA, e3: 32'h0000_0021, e4: 32'hFFFF_FFD4,
                e_p0: 32'hFFFF_FF80};
    vecs[2] = '{b0: 8'h7F, gap: 0, early_rdy: 1,
                o1: 32'h7FFF_FFFF, o2: 32'h8000_0000, o3: 32'hFFFF_FFFF, o4: 32'd5,
                e1: 32'h7FFF_FFFF, e2: 32'h8000_0000, e3: 32'hFFFF_FFFF, e4: 32'h0000_0005,
                e_p0: 32'h0000_007F};

    // Power-on reset
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    @(negedge clk);
    check("por_s_ready_rise", 32'(s_ready), 32'd1);

    // Whole-frame vectors
    for (int v = 0; v < 3; v++) begin
      out1 = vecs[v].o1; out2 = vecs[v].o2; out3 = vecs[v].o3; out4 = vecs[v].o4;
      do_frame($sformatf("vec%0d", v), vecs[v].b0, vecs[v].gap, vecs[v].early_rdy, 0,
               vecs[v].e1, vecs[v].e2, vecs[v].e3, vecs[v].e4);
      check($sformatf("vec%0d_p0", v), params[31:0], vecs[v].e_p0);
      $display("vec%0d: res=%h %h %h %h p0=%h", v, res1, res2, res3, res4, params[31:0]);
    end
    check("no_err_nominal", 32'(err_cnt), 32'd0);

    // Backpressure: result held 20 cycles while out1 changes underneath
    out1 = 32'd11; out2 = -32'sd22; out3 = 32'd33; out4 = -32'sd44;
    do_frame("bp", 8'h00, 0, 0, 20, 32'd11, 32'hFFFF_FFEA, 32'd33, 32'hFFFF_FFD4);
    $display("bp: res1=%h after hold", res1);

    // Early s_last on byte 10
    for (int k = 0; k < 10; k++) begin
      send_byte(8'(8'h40 + k), k == 9, 0);
      exp_bank[k] = 32'(8'h40 + k);
    end
    check("early_err_high", 32'(err), 32'd1);
    @(negedge clk);
    check("early_err_low", 32'(err), 32'd0);
    check("early_s_ready", 32'(s_ready), 32'd1);
    check_bank("early_partial_bank");
    out1 = 32'd11;
    do_frame("after_early", 8'h00, 0, 0, 0, 32'd11, 32'hFFFF_FFEA, 32'd33, 32'hFFFF_FFD4);
    $display("early_last: recovered, p0=%h", params[31:0]);

    // Missing s_last on byte 77, then three drained bytes
    for (int k = 0; k < NP; k++) begin
      send_byte(8'(std_bytes[k] + 8'd1), 1'b0, 0);
      exp_bank[k] = 32'($signed(8'(std_bytes[k] + 8'd1)));
    end
    check("miss_err_high", 32'(err), 32'd1);
    for (int j = 0; j < 3; j++) send_byte(8'hAA, j == 2, 0);
    check("drain_err_low", 32'(err), 32'd0);
    check("drain_res_valid", 32'(res_valid), 32'd0);
    check_bank("drain_no_write");
    do_frame("after_drain", 8'h00, 0, 0, 0, 32'd11, 32'hFFFF_FFEA, 32'd33, 32'hFFFF_FFD4);
    $display("missing_last: recovered after drain");

    // Reset during byte 40
    for (int k = 0; k < 40; k++) send_byte(std_bytes[k], 1'b0, 0);
    #2 rst = 1'b1;
    #1 check_reset("rst_frame");
    @(negedge clk);
    rst = 1'b0;
    do_frame("after_rst_frame", 8'h00, 0, 0, 0, 32'd11, 32'hFFFF_FFEA, 32'd33, 32'hFFFF_FFD4);
    $display("rst_mid_frame: fresh frame ok");

    // Reset during SETTLE
    send_frame(8'h00, 0);
    #2 rst = 1'b1;
    #1 check_reset("rst_settle");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_settle_no_result", 32'(res_valid), 32'd0);
    out2 = 32'd7;
    do_frame("after_rst_settle", 8'h00, 0, 0, 0, 32'd11, 32'd7, 32'd33, 32'hFFFF_FFD4);
    $display("rst_mid_settle: fresh frame ok");

    repeat (3) @(negedge clk);
    check("err_pulse_total", 32'(err_cnt), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
